// File: rtl/modulo_controlador_contador_4_bits.sv
// ---------------------------------------------------------------------------
// modulo_controlador_contador_4_bits
//
// Purpose:
//   Control FSM for an external 4-bit synchronous up-counter. It clears the
//   counter, lets it count up to a captured terminal value and then either
//   stops (one-shot) or clears and counts again (periodic). It also supports
//   pause and abort. A one-cycle pulse marks every terminal count, and a
//   saturating counter keeps the number of pulses since the last start.
//
// Control semantics:
//   iniciar, pausar and parar are plain levels sampled on every rising edge.
//   There is no handshake. When several are high on the same edge, the one
//   that wins is: clr > parar > terminal detection > pausar > iniciar.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset (also clears the counter)
//   iniciar    start request (OCIOSO / CONCLUIDO only)
//   pausar     high holds the count, low resumes it
//   parar      abort to OCIOSO, no fim
//   modo       0 = one-shot, 1 = periodic (captured on start)
//   limite     terminal count 0..15 (captured on start)
//   q_contador present value of the controlled counter
//   cont_en    counter increment enable (combinational)
//   cont_clr   counter clear
//   cont_prst  counter preset, always 0
//   fim        one-cycle pulse on the cycle after terminal detection
//   ocupado    high in LIMPANDO, CONTANDO and PAUSADO
//   estado     current state code (exposed for debug and checking)
//   ciclos     fim pulses since the last start, saturating at 15
// ---------------------------------------------------------------------------
module modulo_controlador_contador_4_bits (
   input  logic       clk,
   input  logic       clr,
   input  logic       iniciar,
   input  logic       pausar,
   input  logic       parar,
   input  logic       modo,
   input  logic [3:0] limite,
   input  logic [3:0] q_contador,
   output logic       cont_en,
   output logic       cont_clr,
   output logic       cont_prst,
   output logic       fim,
   output logic       ocupado,
   output logic [2:0] estado,
   output logic [3:0] ciclos
);

   typedef enum logic [2:0] {
      OCIOSO    = 3'b000,
      LIMPANDO  = 3'b001,
      CONTANDO  = 3'b010,
      PAUSADO   = 3'b011,
      CONCLUIDO = 3'b100
   } estado_t;

   estado_t    estado_q;
   logic [3:0] lim_reg;
   logic       modo_reg;
   logic       terminal;

   // Terminal count is only meaningful while counting; in PAUSADO the
   // counter may already sit at lim_reg, but the detection waits for resume.
   assign terminal = (estado_q == CONTANDO) && (q_contador == lim_reg);

   always_ff @(posedge clk) begin
      if (clr) begin
         estado_q <= OCIOSO;
         lim_reg  <= 4'd0;
         modo_reg <= 1'b0;
         ciclos   <= 4'd0;
         fim      <= 1'b0;
      end else begin
         // fim is a single-cycle pulse; only the terminal branch raises it.
         fim <= 1'b0;
         if (parar) begin
            // Abort: ciclos, lim_reg and modo_reg keep their values.
            estado_q <= OCIOSO;
         end else begin
            case (estado_q)
               OCIOSO, CONCLUIDO: begin
                  if (iniciar) begin
                     lim_reg  <= limite;
                     modo_reg <= modo;
                     ciclos   <= 4'd0;
                     estado_q <= LIMPANDO;
                  end
               end
               LIMPANDO: begin
                  estado_q <= CONTANDO;
               end
               CONTANDO: begin
                  if (terminal) begin
                     fim <= 1'b1;
                     if (ciclos != 4'hF) begin
                        ciclos <= ciclos + 4'd1;
                     end
                     estado_q <= modo_reg ? LIMPANDO : CONCLUIDO;
                  end else if (pausar) begin
                     estado_q <= PAUSADO;
                  end
               end
               PAUSADO: begin
                  if (!pausar) begin
                     estado_q <= CONTANDO;
                  end
               end
               default: begin
                  // Unused codes recover to idle.
                  estado_q <= OCIOSO;
               end
            endcase
         end
      end
   end

   // The increment is withheld on the edge that detects terminal count, so
   // the counter stays at lim_reg instead of stepping past it.
   assign cont_en   = (estado_q == CONTANDO) && !terminal && !parar && !pausar;
   assign cont_clr  = clr || (estado_q == LIMPANDO);
   assign cont_prst = 1'b0;
   assign ocupado   = (estado_q == LIMPANDO) || (estado_q == CONTANDO) ||
                      (estado_q == PAUSADO);
   assign estado    = estado_q;

endmodule
